mac_divider: RTL and testbench

- Iterative radix-2 restoring divider in the MAC unit; the producer for the accumulator file's divide write port.
- Computes 32-bit signed or unsigned quotient and remainder.
- Writes remainder to the HI and quotient to the LO of a selected accumulator, via DDATAHI/DDATALO qualified by DivDest_C1/DivDest_C2.
- Defers writeback around pipeline holds and same-register conflicts with the main MAC write port.

---
 rtl/mac_divider.sv | 171 +++++++++++++++++
 tb/tb_mac_divider.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_divider.sv
`default_nettype none
// ============================================================================
// Module   : mac_divider
// Brief    : Iterative radix-2 restoring divider for the MAC unit. Produces a
//            32-bit signed/unsigned quotient (LO) and remainder (HI) and
//            writes them to one accumulator through the divide write port,
//            deferring around pipeline holds and main-port conflicts.
// Revision : 1.0 - initial release
// ============================================================================
module mac_divider #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 40
) (
   input  logic              CLK,
   input  logic              RESET_D1_R,
   input  logic              DivStart,
   input  logic              DivSigned,
   input  logic [DATA_W-1:0] DivDividend,
   input  logic [DATA_W-1:0] DivDivisor,
   input  logic [1:0]        DivAcc,
   input  logic              Rhold,
   input  logic              Xcpn,
   input  logic [3:0]        Dest_Acc,
   output logic [ACC_W-1:0]  DDATAHI,
   output logic [ACC_W-1:0]  DDATALO,
   output logic [3:0]        DivDest_C1,
   output logic [3:0]        DivDest_C2,
   output logic              DivBusy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIX  = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   localparam logic [5:0] c_ITER = 6'd32;

   state_t              r_state;
   state_t              w_nstate;
   logic [5:0]          r_cnt;
   logic [DATA_W-1:0]   r_rem;
   logic [DATA_W-1:0]   r_quo;
   logic [DATA_W-1:0]   r_dvs;
   logic [DATA_W-1:0]   r_dvd;
   logic                r_dvd_neg;
   logic                r_dvs_neg;
   logic [1:0]          r_acc;

   logic                w_accept;
   logic                w_wr;
   logic                w_conflict;
   logic [DATA_W-1:0]   w_dvd_mag;
   logic [DATA_W-1:0]   w_dvs_mag;
   logic [DATA_W:0]     w_rem_sh;
   logic [DATA_W:0]     w_diff;
   logic [DATA_W-1:0]   w_q_fix;
   logic [DATA_W-1:0]   w_r_fix;

   // Operand magnitudes; only negative values of a signed divide are negated.
   assign w_dvd_mag = (DivSigned & DivDividend[DATA_W-1]) ? -DivDividend : DivDividend;
   assign w_dvs_mag = (DivSigned & DivDivisor[DATA_W-1])  ? -DivDivisor  : DivDivisor;

   // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
   assign w_rem_sh = {r_rem, r_quo[DATA_W-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};

   // Sign fix-up; a zero divisor overrides with all-ones quotient and the
   // unmodified dividend as remainder, independent of signedness.
   assign w_q_fix = (r_dvs == '0) ? '1 :
                    ((r_dvd_neg ^ r_dvs_neg) ? -r_quo : r_quo);
   assign w_r_fix = (r_dvs == '0) ? r_dvd :
                    (r_dvd_neg ? -r_rem : r_rem);

   // Main MAC port writing either half of the accumulator we are about to write.
   assign w_conflict = (Dest_Acc[3:2] == r_acc) & (Dest_Acc[1] | Dest_Acc[0]);

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET_D1_R) r_state <= ST_IDLE;
      else            r_state <= w_nstate;
   end

   // Next-state, accept and write-cycle decode.
   always_comb begin
      w_nstate = r_state;
      w_accept = 1'b0;
      w_wr     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (DivStart & ~Rhold & ~Xcpn) begin
               w_accept = 1'b1;
               w_nstate = ST_DIV;
            end
         end
         ST_DIV: begin
            if (Xcpn)                w_nstate = ST_IDLE;
            else if (r_cnt == 6'd1)  w_nstate = ST_FIX;
         end
         ST_FIX: begin
            w_nstate = Xcpn ? ST_IDLE : ST_WB;
         end
         ST_WB: begin
            // Once the write cycle is reached, an exception no longer kills it.
            if (~Rhold & ~w_conflict) begin
               w_wr     = 1'b1;
               w_nstate = ST_IDLE;
            end else if (Xcpn) begin
               w_nstate = ST_IDLE;
            end
         end
         default: w_nstate = ST_IDLE;
      endcase
      // A reset cycle never produces a write.
      w_wr = w_wr & ~RESET_D1_R;
   end

   // Operand capture, iteration and sign fix-up datapath.
   always_ff @(posedge CLK) begin
      if (RESET_D1_R) begin
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_dvs     <= '0;
         r_dvd     <= '0;
         r_dvd_neg <= 1'b0;
         r_dvs_neg <= 1'b0;
         r_acc     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_acc     <= DivAcc;
                  r_dvd     <= DivDividend;
                  r_dvd_neg <= DivSigned & DivDividend[DATA_W-1];
                  r_dvs_neg <= DivSigned & DivDivisor[DATA_W-1];
                  r_dvs     <= w_dvs_mag;
                  r_rem     <= '0;
                  r_quo     <= w_dvd_mag;
                  r_cnt     <= c_ITER;
               end
            end
            ST_DIV: begin
               r_cnt <= r_cnt - 6'd1;
               if (!w_diff[DATA_W]) begin
                  r_rem <= w_diff[DATA_W-1:0];
                  r_quo <= {r_quo[DATA_W-2:0], 1'b1};
               end else begin
                  r_rem <= w_rem_sh[DATA_W-1:0];
                  r_quo <= {r_quo[DATA_W-2:0], 1'b0};
               end
            end
            ST_FIX: begin
               r_quo <= w_q_fix;
               r_rem <= w_r_fix;
            end
            default: ;
         endcase
      end
   end

   // Results only toggle the write buses during the actual write cycle.
   assign DDATAHI    = w_wr ? {{(ACC_W-DATA_W){1'b0}}, r_rem} : '0;
   assign DDATALO    = w_wr ? {{(ACC_W-DATA_W){1'b0}}, r_quo} : '0;
   assign DivDest_C1 = w_wr ? {r_acc, 2'b11} : 4'b0000;
   assign DivDest_C2 = w_wr ? {r_acc, 2'b11} : 4'b0000;
   assign DivBusy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mac_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_divider
// Brief    : Directed self-checking bench for mac_divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_divider;

   logic        CLK = 1'b0;
   logic        RESET_D1_R = 1'b1;
   logic        DivStart = 1'b0;
   logic        DivSigned = 1'b0;
   logic [31:0] DivDividend = '0;
   logic [31:0] DivDivisor = '0;
   logic [1:0]  DivAcc = '0;
   logic        Rhold = 1'b0;
   logic        Xcpn = 1'b0;
   logic [3:0]  Dest_Acc = '0;
   logic [39:0] DDATAHI;
   logic [39:0] DDATALO;
   logic [3:0]  DivDest_C1;
   logic [3:0]  DivDest_C2;
   logic        DivBusy;

   int n_vec = 0;
   int n_err = 0;

   mac_divider #(.DATA_W(32), .ACC_W(40)) dut (
      .CLK        (CLK),
      .RESET_D1_R (RESET_D1_R),
      .DivStart   (DivStart),
      .DivSigned  (DivSigned),
      .DivDividend(DivDividend),
      .DivDivisor (DivDivisor),
      .DivAcc     (DivAcc),
      .Rhold      (Rhold),
      .Xcpn       (Xcpn),
      .Dest_Acc   (Dest_Acc),
      .DDATAHI    (DDATAHI),
      .DDATALO    (DDATALO),
      .DivDest_C1 (DivDest_C1),
      .DivDest_C2 (DivDest_C2),
      .DivBusy    (DivBusy)
   );

   always #5 CLK = ~CLK;

   // Present a start request in the next cycle (inputs change at negedge).
   task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] acc);
      @(negedge CLK);
      DivStart = 1'b1; DivSigned = sgn; DivDividend = a; DivDivisor = b; DivAcc = acc;
      Rhold = 1'b0; Xcpn = 1'b0; Dest_Acc = 4'b0000;
   endtask

   // Advance cycle by cycle until a write qualifier appears (bounded).
   task automatic wait_write(output int cyc);
      cyc = 0;
      do begin
         @(negedge CLK);
         DivStart = 1'b0;
         cyc++;
         #1;
      end while (DivDest_C1 === 4'b0000 && cyc < 60);
   endtask

   task automatic test_reset();
      RESET_D1_R = 1'b1;
      repeat (2) @(negedge CLK);
      #1;
      n_vec++; if (DivBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", DivBusy); end
      n_vec++; if (DivDest_C1 !== 4'b0) begin n_err++; $display("FAIL reset_c1: got %b expected 0000", DivDest_C1); end
      n_vec++; if (DivDest_C2 !== 4'b0) begin n_err++; $display("FAIL reset_c2: got %b expected 0000", DivDest_C2); end
      n_vec++; if (DDATAHI !== 40'h0) begin n_err++; $display("FAIL reset_hi: got %h expected 0", DDATAHI); end
      n_vec++; if (DDATALO !== 40'h0) begin n_err++; $display("FAIL reset_lo: got %h expected 0", DDATALO); end
      @(negedge CLK);
      RESET_D1_R = 1'b0;
   endtask

   // One complete divide with no holds: checks latency, data and qualifiers.
   task automatic test_divide(input string name, input logic sgn, input logic [31:0] a,
                              input logic [31:0] b, input logic [1:0] acc,
                              input logic [31:0] exp_q, input logic [31:0] exp_r);
      int cyc;
      start_div(sgn, a, b, acc);
      wait_write(cyc);
      n_vec++; if (cyc !== 34) begin n_err++; $display("FAIL %s latency: got %0d expected 34", name, cyc); end
      n_vec++; if (DDATALO !== {8'h00, exp_q}) begin n_err++; $display("FAIL %s quotient: got %h expected %h", name, DDATALO, {8'h00, exp_q}); end
      n_vec++; if (DDATAHI !== {8'h00, exp_r}) begin n_err++; $display("FAIL %s remainder: got %h expected %h", name, DDATAHI, {8'h00, exp_r}); end
      n_vec++; if (DivDest_C1 !== {acc, 2'b11}) begin n_err++; $display("FAIL %s c1: got %b expected %b", name, DivDest_C1, {acc, 2'b11}); end
      n_vec++; if (DivDest_C2 !== {acc, 2'b11}) begin n_err++; $display("FAIL %s c2: got %b expected %b", name, DivDest_C2, {acc, 2'b11}); end
      n_vec++; if (DivBusy !== 1'b1) begin n_err++; $display("FAIL %s busy_wr: got %b expected 1", name, DivBusy); end
      @(negedge CLK); #1;
      n_vec++; if (DivBusy !== 1'b0) begin n_err++; $display("FAIL %s busy_after: got %b expected 0", name, DivBusy); end
      n_vec++; if (DivDest_C1 !== 4'b0 || DDATALO !== 40'h0) begin n_err++; $display("FAIL %s after_wr: got c1=%b lo=%h expected 0000/0", name, DivDest_C1, DDATALO); end
   endtask

   // Rhold at result time for 3 cycles, then main port hits acc0 for 2.
   task automatic test_deferral();
      int bad;
      bad = 0;
      start_div(1'b0, 32'd100, 32'd7, 2'd0);
      for (int c = 1; c <= 38; c++) begin
         @(negedge CLK);
         DivStart = 1'b0;
         Rhold    = (c >= 34 && c <= 36);
         Dest_Acc = (c >= 37) ? 4'b0001 : 4'b0000;
         #1;
         if (DivDest_C1 !== 4'b0 || DivDest_C2 !== 4'b0) bad++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL defer_quiet: got %0d write cycles expected 0", bad); end
      n_vec++; if (DivBusy !== 1'b1) begin n_err++; $display("FAIL defer_busy: got %b expected 1", DivBusy); end
      // Main port writing a different accumulator is not a conflict.
      @(negedge CLK);
      Rhold = 1'b0; Dest_Acc = 4'b0111;
      #1;
      n_vec++; if (DivDest_C1 !== 4'b0011) begin n_err++; $display("FAIL defer_c1: got %b expected 0011", DivDest_C1); end
      n_vec++; if (DDATALO !== 40'h0E || DDATAHI !== 40'h02) begin n_err++; $display("FAIL defer_data: got hi=%h lo=%h expected 02/0E", DDATAHI, DDATALO); end
      @(negedge CLK);
      Dest_Acc = 4'b0000;
      #1;
      n_vec++; if (DivDest_C1 !== 4'b0 || DivBusy !== 1'b0) begin n_err++; $display("FAIL defer_once: got c1=%b busy=%b expected 0000/0", DivDest_C1, DivBusy); end
   endtask

   // Exception at DIV cycle 10, immediate restart, ignored starts while busy.
   task automatic test_xcpn_and_busy();
      int bad;
      int cyc;
      bad = 0;
      start_div(1'b0, 32'd1000, 32'd3, 2'd1);
      for (int c = 1; c <= 10; c++) begin
         @(negedge CLK);
         DivStart = 1'b0;
         Xcpn = (c == 10);
         #1;
         if (DivDest_C1 !== 4'b0) bad++;
      end
      n_vec++; if (DivBusy !== 1'b1) begin n_err++; $display("FAIL xcpn_busy_before: got %b expected 1", DivBusy); end
      // New start in the very next cycle, while the abort takes effect.
      start_div(1'b0, 32'd50, 32'd6, 2'd2);
      #1;
      n_vec++; if (DivBusy !== 1'b0) begin n_err++; $display("FAIL xcpn_busy_after: got %b expected 0", DivBusy); end
      cyc = 0;
      do begin
         @(negedge CLK);
         cyc++;
         DivStart    = (cyc == 3 || cyc == 20);
         DivDividend = 32'hDEAD_BEEF; DivDivisor = 32'd5; DivAcc = 2'd3;
         #1;
      end while (DivDest_C1 === 4'b0000 && cyc < 60);
      DivStart = 1'b0;
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL xcpn_nowrite: got %0d write cycles expected 0", bad); end
      n_vec++; if (cyc !== 34) begin n_err++; $display("FAIL restart_latency: got %0d expected 34", cyc); end
      n_vec++; if (DDATALO !== 40'h08 || DDATAHI !== 40'h02) begin n_err++; $display("FAIL restart_data: got hi=%h lo=%h expected 02/08", DDATAHI, DDATALO); end
      n_vec++; if (DivDest_C1 !== 4'b1011) begin n_err++; $display("FAIL restart_c1: got %b expected 1011", DivDest_C1); end
      @(negedge CLK); #1;
      n_vec++; if (DivBusy !== 1'b0) begin n_err++; $display("FAIL restart_idle: got %b expected 0", DivBusy); end
   endtask

   // Reset mid-DIV, then starts blocked by Xcpn or Rhold.
   task automatic test_reset_mid();
      int bad;
      bad = 0;
      start_div(1'b0, 32'd100, 32'd7, 2'd0);
      for (int c = 1; c <= 15; c++) begin
         @(negedge CLK);
         DivStart = 1'b0;
         RESET_D1_R = (c == 15);
      end
      @(negedge CLK);
      RESET_D1_R = 1'b0;
      #1;
      n_vec++; if (DivBusy !== 1'b0 || DivDest_C1 !== 4'b0 || DivDest_C2 !== 4'b0 || DDATAHI !== 40'h0 || DDATALO !== 40'h0)
         begin n_err++; $display("FAIL rst_mid_outputs: got busy=%b c1=%b c2=%b hi=%h lo=%h expected all 0", DivBusy, DivDest_C1, DivDest_C2, DDATAHI, DDATALO); end
      for (int c = 0; c < 30; c++) begin
         @(negedge CLK); #1;
         if (DivDest_C1 !== 4'b0 || DivBusy !== 1'b0) bad++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL rst_mid_nowrite: got %0d active cycles expected 0", bad); end
      start_div(1'b0, 32'd9, 32'd2, 2'd1);
      Xcpn = 1'b1;
      @(negedge CLK);
      DivStart = 1'b0; Xcpn = 1'b0;
      #1;
      n_vec++; if (DivBusy !== 1'b0) begin n_err++; $display("FAIL start_xcpn: got busy %b expected 0", DivBusy); end
      start_div(1'b0, 32'd9, 32'd2, 2'd1);
      Rhold = 1'b1;
      @(negedge CLK);
      DivStart = 1'b0; Rhold = 1'b0;
      #1;
      n_vec++; if (DivBusy !== 1'b0) begin n_err++; $display("FAIL start_rhold: got busy %b expected 0", DivBusy); end
   endtask

   initial begin
      test_reset();
      test_divide("u100_7",   1'b0, 32'd100,        32'd7,          2'd0, 32'h0000_000E, 32'h0000_0002);
      test_divide("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          2'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      test_divide("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  2'd3, 32'hFFFF_FFFD, 32'h0000_0001);
      test_divide("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  2'd2, 32'h8000_0000, 32'h0000_0000);
      test_divide("u_big",    1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  2'd1, 32'h0FFF_FFFF, 32'h0000_000F);
      test_divide("u_div0",   1'b0, 32'd12345,      32'd0,          2'd0, 32'hFFFF_FFFF, 32'h0000_3039);
      test_divide("s_div0",   1'b1, 32'd12345,      32'd0,          2'd3, 32'hFFFF_FFFF, 32'h0000_3039);
      test_deferral();
      test_xcpn_and_busy();
      test_reset_mid();
      test_divide("post_rst", 1'b0, 32'd81,         32'd9,          2'd2, 32'h0000_0009, 32'h0000_0000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
